sha_wb2: RTL

SHA_WB2 -- requirements
Module: sha_wb2

---
 rtl/sha_wb2_pkg.sv | 28 ++
 rtl/sha_core.sv | 104 ++++++++++
 rtl/sha_wb2_fifo.sv | 68 ++++++
 rtl/sha_wb2.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/sha_wb2_pkg.sv
// sha_wb2_pkg: register offsets, CTRL/STATUS bit positions and feeder FSM states
// shared by the sha_wb2 Wishbone wrapper, its FIFO and the testbench.
package sha_wb2_pkg;

  localparam logic [3:0] ADR_CTRL = 4'h0;
  localparam logic [3:0] ADR_DIN  = 4'h4;
  localparam logic [3:0] ADR_HASH = 4'h8;
  localparam logic [3:0] ADR_IDX  = 4'hC;

  localparam int CTRL_INIT     = 0;
  localparam int CTRL_CLR_DONE = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_FULL    = 2;
  localparam int STAT_EMPTY   = 3;
  localparam int STAT_IRQ_EN  = 4;
  localparam int STAT_LVL_LSB = 8;
  localparam int STAT_LVL_W   = 7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FEED = 2'd1,
    S_WAIT = 2'd2
  } feed_state_e;

endpackage

// File: rtl/sha_core.sv
// sha_core: SHA-256 compression engine. Collects 16 words on vld, runs 64 rounds
// (one per clock), accumulates into the digest and pulses done. init restores the IV.
module sha_core (
  input  logic         clk,
  input  logic         rst,
  input  logic         init,
  input  logic         vld,
  input  logic [31:0]  din,
  output logic         done,
  output logic [255:0] hash
);
  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic [0:7][31:0]  h_q, h_d, s_q, s_d, s_nx;
  logic [0:15][31:0] w_q, w_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        t_q, t_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [31:0]       t1, t2, w_nx;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // One round: s = {a,b,c,d,e,f,g,h}; w holds the rolling 16-word schedule window.
  always_comb begin
    t1 = s_q[7] + (rotr(s_q[4], 6) ^ rotr(s_q[4], 11) ^ rotr(s_q[4], 25))
       + ((s_q[4] & s_q[5]) ^ (~s_q[4] & s_q[6])) + K[t_q] + w_q[0];
    t2 = (rotr(s_q[0], 2) ^ rotr(s_q[0], 13) ^ rotr(s_q[0], 22))
       + ((s_q[0] & s_q[1]) ^ (s_q[0] & s_q[2]) ^ (s_q[1] & s_q[2]));
    s_nx = {t1 + t2, s_q[0], s_q[1], s_q[2], s_q[3] + t1, s_q[4], s_q[5], s_q[6]};
    w_nx = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
         + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
  end

  always_comb begin
    h_d    = h_q;
    s_d    = s_q;
    w_d    = w_q;
    cnt_d  = cnt_q;
    t_d    = t_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (init) begin
      h_d    = IV;
      cnt_d  = '0;
      t_d    = '0;
      busy_d = 1'b0;
    end else if (busy_q) begin
      s_d = s_nx;
      w_d = {w_q[1:15], w_nx};
      t_d = t_q + 1'b1;
      if (t_q == 6'd63) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + s_nx[i];
      end
    end else if (vld) begin
      w_d   = {w_q[1:15], din};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == 4'd15) begin
        busy_d = 1'b1;
        t_d    = '0;
        s_d    = h_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_q    <= IV;
      s_q    <= '0;
      w_q    <= '0;
      cnt_q  <= '0;
      t_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      h_q    <= h_d;
      s_q    <= s_d;
      w_q    <= w_d;
      cnt_q  <= cnt_d;
      t_q    <= t_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign done = done_q;
  assign hash = h_q;

endmodule

// File: rtl/sha_wb2_fifo.sv
// sha_wb2_fifo: synchronous input-word FIFO with occupancy level and flush.
// Read data is combinational from the head entry so a pop can be registered downstream.
module sha_wb2_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign level   = cnt_q;
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sha_wb2.sv
// sha_wb2: Wishbone slave feeding a SHA-256 core from a word FIFO, with digest readback.
// Optional level interrupt enabled by defining SHA_WB2_IRQ_EN.
module sha_wb2
  import sha_wb2_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int HASH_WORDS = 8,
  parameter int BLK_WORDS  = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        SHA_CYC_I,
  input  logic        SHA_LOCK_I,
  input  logic [2:0]  SHA_CTI_I,
  input  logic [1:0]  SHA_BTE_I,
  input  logic [3:0]  SHA_SEL_I,
  input  logic        SHA_STB_I,
  input  logic        SHA_WE_I,
  input  logic [3:0]  SHA_ADR_I,
  input  logic [31:0] SHA_DAT_I,
  output logic [31:0] SHA_DAT_O,
  output logic        SHA_ACK_O,
  output logic        SHA_ERR_O,
  output logic        SHA_RTY_O,
  output logic        SHA_IRQ_O,
  output feed_state_e dbg_state_o
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = (HASH_WORDS > 1) ? $clog2(HASH_WORDS) : 1;
  localparam int CNT_W = $clog2(BLK_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLK_WORDS - 1);

  logic             accept, bus_wr, bus_rd, init, clr_done, push, din_err, pop;
  logic             fifo_full, fifo_empty, core_done, irq_en, unused_ok;
  logic [LVL_W-1:0] fifo_level;
  logic [31:0]      fifo_dout, status;
  logic [255:0]     core_hash;
  logic [0:7][31:0] hash_words;
  logic [2:0]       idx_sel;

  feed_state_e      state_q, state_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d, ack_q, ack_d, err_q, err_d;
  logic [31:0]      dat_q, dat_d, core_din_q, core_din_d;
  logic             core_init_q, core_init_d, core_vld_q, core_vld_d;

  // Bus handshake: a strobe is taken only while neither ACK nor ERR is showing,
  // and exactly one of them answers it for one cycle on the following clock.
  assign accept   = SHA_STB_I & ~ack_q & ~err_q;
  assign bus_wr   = accept & SHA_WE_I;
  assign bus_rd   = accept & ~SHA_WE_I;
  assign init     = bus_wr & (SHA_ADR_I == ADR_CTRL) & SHA_DAT_I[CTRL_INIT];
  assign clr_done = bus_wr & (SHA_ADR_I == ADR_CTRL) & SHA_DAT_I[CTRL_CLR_DONE];
  assign push     = bus_wr & (SHA_ADR_I == ADR_DIN) & ~fifo_full;
  assign din_err  = bus_wr & (SHA_ADR_I == ADR_DIN) & fifo_full;

  assign hash_words = core_hash;
  assign idx_sel    = 3'(idx_q);

  sha_wb2_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk(CLK_I), .rst(RST_I), .flush(init), .push(push), .din(SHA_DAT_I),
    .pop(pop), .dout(fifo_dout), .level(fifo_level), .full(fifo_full), .empty(fifo_empty)
  );

  sha_core u_core (
    .clk(CLK_I), .rst(RST_I), .init(core_init_q), .vld(core_vld_q), .din(core_din_q),
    .done(core_done), .hash(core_hash)
  );

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_d = S_FEED;
      S_FEED:  if (pop && wcnt_q == LAST_WORD) state_d = S_WAIT;
      S_WAIT:  if (core_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (init) state_d = S_IDLE;
  end

  always_comb begin
    pop = (state_q == S_FEED) & ~fifo_empty & ~init;
  end

  always_comb begin
    status                                  = '0;
    status[STAT_BUSY]                       = (state_q != S_IDLE) | ~fifo_empty;
    status[STAT_DONE]                       = done_q;
    status[STAT_FULL]                       = fifo_full;
    status[STAT_EMPTY]                      = fifo_empty;
    status[STAT_IRQ_EN]                     = irq_en;
    status[STAT_LVL_LSB +: STAT_LVL_W]      = STAT_LVL_W'(fifo_level);
  end

  always_comb begin
    wcnt_d = wcnt_q;
    if (pop) wcnt_d = wcnt_q + 1'b1;
    if (state_q == S_WAIT && core_done) wcnt_d = '0;
    if (init) wcnt_d = '0;

    // Completion beats a simultaneous clear; INIT beats everything.
    done_d = done_q;
    if (clr_done) done_d = 1'b0;
    if (state_q == S_WAIT && core_done) done_d = 1'b1;
    if (init) done_d = 1'b0;

    idx_d = idx_q;
    if (bus_rd && SHA_ADR_I == ADR_HASH)
      idx_d = (idx_q == IDX_W'(HASH_WORDS - 1)) ? '0 : idx_q + 1'b1;
    if (bus_wr && SHA_ADR_I == ADR_IDX) idx_d = IDX_W'(SHA_DAT_I % HASH_WORDS);
    if (init) idx_d = '0;

    ack_d = accept & ~din_err;
    err_d = din_err;
    dat_d = '0;
    if (bus_rd) begin
      case (SHA_ADR_I)
        ADR_CTRL: dat_d = status;
        ADR_HASH: dat_d = hash_words[idx_sel];
        ADR_IDX:  dat_d = 32'(idx_q);
        default:  dat_d = '0;
      endcase
    end

    core_init_d = init;
    core_vld_d  = pop;
    core_din_d  = pop ? fifo_dout : core_din_q;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      wcnt_q      <= '0;
      idx_q       <= '0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      dat_q       <= '0;
      core_init_q <= 1'b0;
      core_vld_q  <= 1'b0;
      core_din_q  <= '0;
    end else begin
      wcnt_q      <= wcnt_d;
      idx_q       <= idx_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      dat_q       <= dat_d;
      core_init_q <= core_init_d;
      core_vld_q  <= core_vld_d;
      core_din_q  <= core_din_d;
    end
  end

`ifdef SHA_WB2_IRQ_EN
  logic irq_en_q, irq_en_d, irq_q, irq_d;

  always_comb begin
    irq_en_d = irq_en_q;
    if (bus_wr && SHA_ADR_I == ADR_CTRL) irq_en_d = SHA_DAT_I[CTRL_IRQ_EN];
    irq_d = done_d & irq_en_d & fifo_empty;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign irq_en    = irq_en_q;
  assign SHA_IRQ_O = irq_q;
`else
  assign irq_en    = 1'b0;
  assign SHA_IRQ_O = 1'b0;
`endif

  assign SHA_DAT_O   = dat_q;
  assign SHA_ACK_O   = ack_q;
  assign SHA_ERR_O   = err_q;
  assign SHA_RTY_O   = 1'b0;
  assign dbg_state_o = state_q;
  assign unused_ok   = ^{SHA_CYC_I, SHA_LOCK_I, SHA_CTI_I, SHA_BTE_I, SHA_SEL_I};

endmodule
